dsram_like_responder: RTL
=========================

Name: dsram_like_responder

Overview:
- Responder (slave) end of the SRAM-like data bus driven by the execute stage: req/wr/size/addr/wstrb/wdata in, addr_ok/data_ok/rdata out.
- Holds a word-organised data memory and accepts requests in order.
- Returns one data_ok per accepted request after a fixed latency, with a bounded number of outstanding requests.
- Used as the data-side memory model in core-level simulation, and as the protocol-checking endpoint for load/store verification.

Parameters:
- ADDR_W, 10: word-index width; memory holds 2^ADDR_W 32-bit words.
- LAT, 2: cycles from address handshake to data_ok; legal range 1..15.
- QDEPTH, 4: maximum outstanding (accepted, not yet responded) requests; power of two, 2..8.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid from initiator.
- wr  input  1  1 = write, 0 = read.
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- addr  input  32  byte address.
- wstrb  input  4  write byte enables; ignored for reads.
- wdata  input  32  write data, already lane-replicated by the initiator.
- stall_addr  input  1  test hook; when 1, addr_ok is forced to 0.
- addr_ok  output  1  request accepted this cycle (handshake = req & addr_ok).
- data_ok  output  1  response for the oldest outstanding request, one cycle per request.
- rdata  output  32  read word, valid when data_ok is 1.
- outstanding  output  4  number of queued requests.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset values: addr_ok 0, data_ok 0, rdata 0, outstanding 0, proto_err 0.
- Reset clears the queue and all pending responses; responses in flight are dropped, not delivered.
- Memory contents are not cleared by reset; simulation initialises memory to zero at time 0.
- addr_ok = req & ~stall_addr & (outstanding != QDEPTH). It is combinational on req but depends only on the registered count.
  - When the queue is full, addr_ok stays 0 even if the head entry retires in the same cycle.
- Word select: addr[ADDR_W+1:2]. Higher address bits are ignored (aliasing). addr[1:0] is used only for the proto_err check.
- Write handshake in cycle T:
  - Each byte lane i with wstrb[i]=1 is updated from wdata[8i+7:8i] at the end of cycle T.
  - The entry is queued with rdata payload 0.
- Read handshake in cycle T:
  - The word is sampled in cycle T and queued as the payload.
  - A read in cycle T+1 or later observes all writes handshaken at cycle T or earlier.
  - The full 32-bit word is returned; the initiator selects the lane.
- Queue: in-order FIFO of QDEPTH entries. Each entry holds the payload and a countdown loaded with LAT-1 at accept. All valid entries decrement every cycle, saturating at 0.
- data_ok is registered. A request handshaken in cycle T produces data_ok=1 in exactly cycle T+LAT; rdata carries its payload in the same cycle.
- Back-to-back handshakes produce back-to-back data_ok cycles.
- rdata holds its last value when data_ok=0.
- outstanding is incremented on handshake and decremented when the head's data_ok is issued. If both happen in one cycle it is unchanged.
- An entry is counted from the cycle after its handshake through its data_ok cycle inclusive.
- proto_err is set on any handshake that has any of:
  - size==3;
  - size==2 with addr[1:0]!=0;
  - size==1 with addr[0]=1;
  - wr=1 with wstrb==0;
  - wr=1 with wstrb bits outside the lanes selected by size and addr[1:0].
- On a proto_err handshake the request is still executed and answered normally. proto_err stays set until reset.
- A request with req=0, or with req=1 and addr_ok=0, has no side effects. The initiator may change or withdraw req freely before addr_ok; the responder does not require req to be held.
- No ordering hazard between response and new accept: one handshake per cycle maximum, one data_ok per cycle maximum.

Test Plan:
- Write then read, LAT=2:
  - Write addr 0x40, wdata 0x12345678, wstrb 0xF, size 2 in cycle 0 -> data_ok in cycle 2.
  - Read 0x40 in cycle 1 -> data_ok in cycle 3 with rdata 0x12345678; proto_err 0.
- Byte write: word 0x40 = 0x12345678; write addr 0x41, size 0, wstrb 0x2, wdata 0xABABABAB -> subsequent read of 0x40 returns 0x1234AB78.
- Queue full, QDEPTH=4, LAT=8:
  - Reads held on 5 consecutive cycles -> addr_ok 1 for the first 4, 0 on the 5th; outstanding reads 4.
  - First data_ok 8 cycles after the first handshake; 5th request accepted in the cycle after the first retire.
- stall_addr=1 for 3 cycles with req=1 -> addr_ok 0, no memory change, no data_ok. Deassert -> accepted that cycle, data_ok LAT cycles later.
- Protocol errors:
  - size 2 at addr 0x42 -> proto_err 1 the cycle after the handshake, and data_ok still issued.
  - Write size 1, addr 0x40, wstrb 0xC -> proto_err remains 1.
- Reset mid-flight: 3 reads accepted, reset asserted before any data_ok -> no data_ok ever issued for them, outstanding 0, proto_err 0. Previously written memory data is readable after reset.

Source files
------------

// File: rtl/dsram_like_responder_if.sv
// SRAM-like data bus between the execute stage (master) and the data memory responder (slave).
// The status outputs (outstanding, proto_err) and the stall test hook ride along with the bus.
interface dsram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        stall_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [3:0]  outstanding;
  logic        proto_err;

  modport master (
    output req, wr, size, addr, wstrb, wdata, stall_addr,
    input  addr_ok, data_ok, rdata, outstanding, proto_err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, stall_addr,
    output addr_ok, data_ok, rdata, outstanding, proto_err
  );
endinterface

// File: rtl/dsram_like_responder.sv
// Data-side SRAM-like responder: word memory with byte-lane writes, in-order fixed-latency
// responses through a bounded queue, and a sticky protocol-violation flag.
module dsram_like_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dsram_like_responder_if.slave bus
);
  localparam int               PTR_W    = $clog2(QDEPTH);
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
  localparam logic [3:0]       Q_FULL   = 4'(QDEPTH);

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      payload;
  } entry_t;

  // Zero at time 0 so simulation starts from a known memory image.
  logic [31:0] mem_q [2**ADDR_W] = '{default: '0};

  entry_t [QDEPTH-1:0] q_q, q_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]          count_q, count_d;
  logic                data_ok_q, data_ok_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                proto_err_q, proto_err_d;

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       payload_in;
  logic [3:0]        lane_mask;
  logic              hs;
  logic              bad_req;
  logic              pop;
  entry_t            head;
  logic              unused_addr_bits;

  assign word_idx         = bus.addr[ADDR_W+1:2];
  assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];

  // Acceptance looks only at the registered count, so a retire in the same cycle
  // cannot open a slot early.
  assign hs = bus.req & ~bus.stall_addr & (count_q != Q_FULL) & ~reset;

  assign payload_in = bus.wr ? 32'd0 : mem_q[word_idx];
  assign head       = q_q[rd_ptr_q];

  always_comb begin
    unique case (bus.size)
      2'd0:    lane_mask = 4'b0001 << bus.addr[1:0];
      2'd1:    lane_mask = 4'b0011 << bus.addr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  assign bad_req = (bus.size == 2'd3)
                 | ((bus.size == 2'd2) & (bus.addr[1:0] != 2'd0))
                 | ((bus.size == 2'd1) & bus.addr[0])
                 | (bus.wr & (bus.wstrb == 4'd0))
                 | (bus.wr & ((bus.wstrb & ~lane_mask) != 4'd0));

  // NOTE: every output of this block is given a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    q_d         = q_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_ok_d   = 1'b0;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    proto_err_d = proto_err_q | (hs & bad_req);
    count_d     = count_q + {3'd0, hs} - {3'd0, data_ok_q};

    if (LAT == 1) begin
      // data_ok is registered, so a single-cycle latency bypasses the queue entirely.
      data_ok_d = hs;
      if (hs) rdata_d = payload_in;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_q[i].valid && q_q[i].cnt != '0) q_d[i].cnt = q_q[i].cnt - CNT_W'(1);
      end
      // The head moves into the output register one cycle before its data_ok cycle.
      pop = head.valid && (head.cnt == CNT_W'(1));
      if (pop) begin
        q_d[rd_ptr_q].valid = 1'b0;
        rd_ptr_d            = rd_ptr_q + PTR_W'(1);
        data_ok_d           = 1'b1;
        rdata_d             = head.payload;
      end
      if (hs) begin
        q_d[wr_ptr_q] = '{valid: 1'b1, cnt: CNT_LOAD, payload: payload_in};
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_ok_q   <= 1'b0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_ok_q   <= data_ok_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: the data array is deliberately left out of reset; its contents must survive
  // a reset, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (hs && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem_q[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.addr_ok     = hs;
  assign bus.data_ok     = data_ok_q;
  assign bus.rdata       = rdata_q;
  assign bus.outstanding = count_q;
  assign bus.proto_err   = proto_err_q;
endmodule
